// File: rtl/bank_cmd_sched.sv
// bank_cmd_sched: in-order request FIFO feeding a single-bank command FSM.
// Writes issue a one-cycle w_en then one wait cycle; reads issue a one-cycle
// r_en, wait two sense cycles, then capture sa_dout as the response.
// Optional macro BANK_CMD_SCHED_FWD_EN adds read-after-write forwarding of the
// most recently written address/data, bypassing the bank for matching reads.
module bank_cmd_sched #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              w_en,
   output logic              r_en,
   output logic [ADDR_W-1:0] bank_addr,
   output logic [DATA_W-1:0] bank_wdata,
   input  logic [DATA_W-1:0] sa_dout,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_WAIT,
      RD,
      SENSE1,
      SENSE2,
      CAPTURE
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_fifoAddr [DEPTH];
   logic [DATA_W-1:0] r_fifoData [DEPTH];
   logic [DEPTH-1:0]  r_fifoWe;
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [PTR_W:0]    r_count;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_headAddr;
   logic [DATA_W-1:0] w_headData;
   logic              w_headWe;

`ifdef BANK_CMD_SCHED_FWD_EN
   logic              r_fwdValid;
   logic [ADDR_W-1:0] r_fwdAddr;
   logic [DATA_W-1:0] r_fwdData;
   logic              r_fwdHit;
`endif

   assign w_full     = (r_count == FULL_CNT);
   assign w_empty    = (r_count == '0);
   assign req_ready  = !w_full;
   assign w_push     = req_valid && !w_full;
   assign w_pop      = (r_state == IDLE) && !w_empty;
   assign w_headAddr = r_fifoAddr[r_rdPtr];
   assign w_headData = r_fifoData[r_rdPtr];
   assign w_headWe   = r_fifoWe[r_rdPtr];
   assign busy       = !w_empty || (r_state != IDLE);

   // FIFO payload storage; contents are don't-care while the count says empty
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifoAddr[r_wrPtr] <= req_addr;
         r_fifoData[r_wrPtr] <= req_wdata;
         r_fifoWe[r_wrPtr]   <= req_we;
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Command FSM with registered strobes, held bank operands and read response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         w_en       <= 1'b0;
         r_en       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         bank_addr  <= '0;
         bank_wdata <= '0;
`ifdef BANK_CMD_SCHED_FWD_EN
         r_fwdValid <= 1'b0;
         r_fwdAddr  <= '0;
         r_fwdData  <= '0;
         r_fwdHit   <= 1'b0;
`endif
      end else begin
         w_en      <= 1'b0;
         r_en      <= 1'b0;
         rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  bank_addr  <= w_headAddr;
                  bank_wdata <= w_headData;
                  if (w_headWe) begin
                     r_state <= WR;
                     w_en    <= 1'b1;
`ifdef BANK_CMD_SCHED_FWD_EN
                     r_fwdValid <= 1'b1;
                     r_fwdAddr  <= w_headAddr;
                     r_fwdData  <= w_headData;
`endif
                  end
`ifdef BANK_CMD_SCHED_FWD_EN
                  else if (r_fwdValid && (r_fwdAddr == w_headAddr)) begin
                     r_state  <= CAPTURE;
                     r_fwdHit <= 1'b1;
                  end
`endif
                  else begin
                     r_state <= RD;
                     r_en    <= 1'b1;
                  end
               end
            end
            WR:      r_state <= WR_WAIT;
            WR_WAIT: r_state <= IDLE;
            RD:      r_state <= SENSE1;
            SENSE1:  r_state <= SENSE2;
            SENSE2:  r_state <= CAPTURE;
            CAPTURE: begin
               rsp_valid <= 1'b1;
`ifdef BANK_CMD_SCHED_FWD_EN
               rsp_rdata <= r_fwdHit ? r_fwdData : sa_dout;
               r_fwdHit  <= 1'b0;
`else
               rsp_rdata <= sa_dout;
`endif
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bank_cmd_sched.sv
// tb_bank_cmd_sched: directed vector table plus hand-written sequences for
// back-pressure ordering and asynchronous reset during a read.
module tb_bank_cmd_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [5:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       w_en;
   logic       r_en;
   logic [5:0] bank_addr;
   logic [7:0] bank_wdata;
   logic [7:0] sa_dout = '0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       we;
      logic [5:0] addr;
      logic [7:0] wdata;
      logic [7:0] sa;
      int         expWen;
      int         expWenIdx;
      int         expRen;
      int         expRenIdx;
      int         expRsp;
      int         expRspIdx;
      logic [7:0] expRdata;
   } vec_t;

   typedef struct {
      int wenCount;
      int wenIdx;
      int renCount;
      int renIdx;
      int rspCount;
      int rspIdx;
      int rspData;
      int issueAddr;
      int issueWdata;
      int unstable;
      int overlap;
      int busyAt0;
      int busyEnd;
      int rdataEnd;
   } obs_t;

   vec_t vecs [8];

   bank_cmd_sched #(.ADDR_W(6), .DATA_W(8), .DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .w_en       (w_en),
      .r_en       (r_en),
      .bank_addr  (bank_addr),
      .bank_wdata (bank_wdata),
      .sa_dout    (sa_dout),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .busy       (busy)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Hard stop in case a sequence never completes
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Push one request from idle and observe eight sampled cycles afterwards
   task automatic applyStimulus(input vec_t v, output obs_t o);
      o = '{0, -1, 0, -1, 0, -1, -1, 0, 0, 0, 0, 0, 0, 0};
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      sa_dout   = ~v.sa;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) o.busyAt0 = int'(busy);
         if (w_en) begin
            o.wenCount++;
            if (o.wenIdx < 0) o.wenIdx = k;
         end
         if (r_en) begin
            o.renCount++;
            if (o.renIdx < 0) o.renIdx = k;
         end
         if (rsp_valid) begin
            o.rspCount++;
            if (o.rspIdx < 0) begin
               o.rspIdx  = k;
               o.rspData = int'(rsp_rdata);
            end
         end
         if (w_en && r_en) o.overlap++;
         if (k == 1) begin
            o.issueAddr  = int'(bank_addr);
            o.issueWdata = int'(bank_wdata);
         end
         if (k >= 1 && busy &&
             ((int'(bank_addr) != o.issueAddr) || (int'(bank_wdata) != o.issueWdata)))
            o.unstable++;
         if (k == 3) sa_dout = v.sa;
         if (k == 5) sa_dout = ~v.sa;
         if (k == 7) begin
            o.busyEnd  = int'(busy);
            o.rdataEnd = int'(rsp_rdata);
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic checkOutput(input int idx, input vec_t v, input obs_t o);
      checkVal($sformatf("v%0d.wenCount", idx), o.wenCount, v.expWen);
      checkVal($sformatf("v%0d.wenIdx", idx), o.wenIdx, v.expWenIdx);
      checkVal($sformatf("v%0d.renCount", idx), o.renCount, v.expRen);
      checkVal($sformatf("v%0d.renIdx", idx), o.renIdx, v.expRenIdx);
      checkVal($sformatf("v%0d.rspCount", idx), o.rspCount, v.expRsp);
      checkVal($sformatf("v%0d.rspIdx", idx), o.rspIdx, v.expRspIdx);
      checkVal($sformatf("v%0d.bankAddr", idx), o.issueAddr, int'(v.addr));
      checkVal($sformatf("v%0d.bankWdata", idx), o.issueWdata, int'(v.wdata));
      checkVal($sformatf("v%0d.operandUnstable", idx), o.unstable, 0);
      checkVal($sformatf("v%0d.wenRenOverlap", idx), o.overlap, 0);
      checkVal($sformatf("v%0d.busyAfterPush", idx), o.busyAt0, 1);
      checkVal($sformatf("v%0d.busyAtEnd", idx), o.busyEnd, 0);
      checkVal($sformatf("v%0d.rdataHeld", idx), o.rdataEnd, int'(v.expRdata));
      if (v.expRsp != 0)
         checkVal($sformatf("v%0d.rspData", idx), o.rspData, int'(v.expRdata));
   endtask

   // Main test sequence
   initial begin
      obs_t       obs;
      logic [5:0] expAddr [6];
      logic       expWe [6];
      logic [7:0] expData [6];
      logic [5:0] issAddr [$];
      logic       issWe [$];
      logic [7:0] issData [$];
      int         rspCnt;
      int         accepted;
      int         found;
      int         cnt;

      //           we    addr   wdata  sa     wen idx ren idx rsp idx rdata
      vecs[0] = '{1'b1, 6'd3,  8'h15, 8'h00, 1,  1, 0, -1, 0, -1, 8'h00};
      vecs[1] = '{1'b0, 6'd3,  8'h00, 8'hA5, 0, -1, 1,  1, 1,  5, 8'hA5};
      vecs[2] = '{1'b1, 6'd63, 8'hFF, 8'h00, 1,  1, 0, -1, 0, -1, 8'hA5};
      vecs[3] = '{1'b0, 6'd0,  8'h12, 8'h00, 0, -1, 1,  1, 1,  5, 8'h00};
      vecs[4] = '{1'b0, 6'd63, 8'h00, 8'h5A, 0, -1, 1,  1, 1,  5, 8'h5A};
      vecs[5] = '{1'b1, 6'd0,  8'h00, 8'h00, 1,  1, 0, -1, 0, -1, 8'h5A};
      vecs[6] = '{1'b1, 6'd7,  8'h3C, 8'h00, 1,  1, 0, -1, 0, -1, 8'h5A};
      vecs[7] = '{1'b0, 6'd7,  8'h00, 8'h96, 0, -1, 1,  1, 1,  5, 8'h96};

      // Reset takes effect before any clock edge
      #2 rst_n = 1'b0;
      #1;
      checkVal("reset.w_en", int'(w_en), 0);
      checkVal("reset.r_en", int'(r_en), 0);
      checkVal("reset.rsp_valid", int'(rsp_valid), 0);
      checkVal("reset.rsp_rdata", int'(rsp_rdata), 0);
      checkVal("reset.bank_addr", int'(bank_addr), 0);
      checkVal("reset.bank_wdata", int'(bank_wdata), 0);
      checkVal("reset.busy", int'(busy), 0);
      checkVal("reset.req_ready", int'(req_ready), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i], obs);
         checkOutput(i, vecs[i], obs);
      end

      // Back-pressure: one read in flight, then five queued requests
      expAddr[0] = 6'd10; expWe[0] = 1'b0; expData[0] = 8'h00;
      expAddr[1] = 6'd1;  expWe[1] = 1'b1; expData[1] = 8'h11;
      expAddr[2] = 6'd2;  expWe[2] = 1'b0; expData[2] = 8'h00;
      expAddr[3] = 6'd3;  expWe[3] = 1'b1; expData[3] = 8'h33;
      expAddr[4] = 6'd4;  expWe[4] = 1'b0; expData[4] = 8'h00;
      expAddr[5] = 6'd5;  expWe[5] = 1'b1; expData[5] = 8'h55;
      rspCnt   = 0;
      accepted = 0;
      found    = 0;
      sa_dout  = 8'h77;
      fork
         begin
            for (int c = 0; c < 70; c++) begin
               @(negedge clk);
               if (w_en || r_en) begin
                  issAddr.push_back(bank_addr);
                  issWe.push_back(w_en);
                  issData.push_back(bank_wdata);
               end
               if (rsp_valid) rspCnt++;
            end
         end
         begin
            req_valid = 1'b1;
            req_we    = expWe[0];
            req_addr  = expAddr[0];
            req_wdata = expData[0];
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            for (int c = 0; c < 10 && found == 0; c++) begin
               if (r_en) found = 1;
               else @(negedge clk);
            end
            checkVal("b2b.firstReadIssued", found, 1);
            cnt = 0;
            while (accepted < 5 && cnt < 40) begin
               int willTake;
               req_valid = 1'b1;
               req_we    = expWe[accepted+1];
               req_addr  = expAddr[accepted+1];
               req_wdata = expData[accepted+1];
               willTake  = int'(req_ready);
               @(posedge clk);
               @(negedge clk);
               cnt++;
               if (willTake != 0) begin
                  accepted++;
                  if (accepted == 4)
                     checkVal("b2b.readyLowAfter4", int'(req_ready), 0);
               end
            end
            req_valid = 1'b0;
            checkVal("b2b.allAccepted", accepted, 5);
         end
      join
      checkVal("b2b.issueCount", issAddr.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < issAddr.size()) begin
            checkVal($sformatf("b2b.issue%0d.addr", i), int'(issAddr[i]), int'(expAddr[i]));
            checkVal($sformatf("b2b.issue%0d.we", i), int'(issWe[i]), int'(expWe[i]));
            if (expWe[i])
               checkVal($sformatf("b2b.issue%0d.wdata", i), int'(issData[i]), int'(expData[i]));
         end
      end
      checkVal("b2b.rspCount", rspCnt, 3);
      checkVal("b2b.lastRdata", int'(rsp_rdata), 8'h77);
      checkVal("b2b.busyEnd", int'(busy), 0);

      // Reset during SENSE1 with two requests still queued
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 6'd20;
      @(posedge clk);
      @(negedge clk);
      req_we    = 1'b1;
      req_addr  = 6'd21;
      req_wdata = 8'h21;
      @(posedge clk);
      @(negedge clk);
      req_we    = 1'b0;
      req_addr  = 6'd22;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkVal("rst.busyBefore", int'(busy), 1);
      checkVal("rst.bankAddrBefore", int'(bank_addr), 20);
      #2 rst_n = 1'b0;
      #1;
      checkVal("rst.busy", int'(busy), 0);
      checkVal("rst.req_ready", int'(req_ready), 1);
      checkVal("rst.bank_addr", int'(bank_addr), 0);
      checkVal("rst.bank_wdata", int'(bank_wdata), 0);
      checkVal("rst.rsp_rdata", int'(rsp_rdata), 0);
      checkVal("rst.rsp_valid", int'(rsp_valid), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (w_en || r_en || rsp_valid) cnt++;
      end
      checkVal("rst.noActivityAfter", cnt, 0);
      checkVal("rst.busyAfter", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
